// File: rtl/alu_seq_responder_if.sv
// Request/response channel between an operation issuer and the ALU responder.
// The issuer drives the request fields and rsp_ready; the responder drives the rest.
interface alu_seq_responder_if #(
    parameter int WIDTH = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic             req_mode;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [WIDTH-1:0] rsp_result_hi;
    logic             rsp_c_out;
    logic             rsp_overflow;
    logic             rsp_zero;

    modport master (
        output req_valid, req_op, req_mode, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_result_hi,
               rsp_c_out, rsp_overflow, rsp_zero
    );

    modport slave (
        input  req_valid, req_op, req_mode, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_result_hi,
               rsp_c_out, rsp_overflow, rsp_zero
    );
endinterface

// File: rtl/alu_seq_responder.sv
// Handshaked ALU: single-cycle ADD/SUB/shift, iterative shift-add multiply and
// restoring divide over WIDTH cycles, result held on the response channel until taken.
//
// state | meaning
// IDLE  | ready for a request; operands captured on handshake
// EXEC  | single-cycle ops (ADD/SUB/shifts/reserved) evaluated into response regs
// PREP  | MUL/DIV: load operand magnitudes, arm the iteration counter
// ITER  | one multiply or divide step per cycle, WIDTH cycles
// FIX   | apply signs, special cases and flags to the iterated result
// DONE  | response valid, held until rsp_ready
module alu_seq_responder #(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    alu_seq_responder_if.slave   bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_SHL = 3'd4;
    localparam logic [2:0] OP_SHR = 3'd5;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             c_q, c_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [WIDTH:0]     add_s;
    logic [WIDTH:0]     sub_s;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_s;
    logic [WIDTH:0]     div_rs;
    logic               div_ge;
    logic [WIDTH-1:0]   div_trial;
    logic               neg_q_sign;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    assign add_s      = {1'b0, a_q} + {1'b0, b_q};
    assign sub_s      = {1'b0, a_q} - {1'b0, b_q};
    assign mag_a      = (mode_q && a_q[WIDTH-1]) ? (~a_q + 1'b1) : a_q;
    assign mag_b      = (mode_q && b_q[WIDTH-1]) ? (~b_q + 1'b1) : b_q;

    // Multiply step: conditionally add multiplicand into the high half, then shift right.
    assign mul_s      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});

    // Divide step: shift the next dividend bit into the partial remainder and trial-subtract.
    assign div_rs     = {hi_q, lo_q[WIDTH-1]};
    assign div_ge     = (div_rs >= {1'b0, m_q});
    assign div_trial  = div_rs[WIDTH-1:0] - m_q;

    assign neg_q_sign = mode_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    assign prod       = {hi_q, lo_q};
    assign prod_s     = neg_q_sign ? (~prod + 1'b1) : prod;
    assign quo_s      = neg_q_sign ? (~lo_q + 1'b1) : lo_q;
    assign rem_s      = (mode_q && a_q[WIDTH-1]) ? (~hi_q + 1'b1) : hi_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            mode_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            res_hi_q <= '0;
            c_q      <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mode_q   <= mode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            c_q      <= c_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        mode_d   = mode_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        c_d      = c_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    mode_d  = bus.req_mode;
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    state_d = (bus.req_op == OP_MUL || bus.req_op == OP_DIV) ? S_PREP : S_EXEC;
                end
            end

            S_EXEC: begin
                res_hi_d = '0;
                c_d      = 1'b0;
                ovf_d    = 1'b0;
                case (op_q)
                    OP_ADD: begin
                        res_d = add_s[WIDTH-1:0];
                        c_d   = add_s[WIDTH];
                        ovf_d = mode_q ? ((a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                          (add_s[WIDTH-1] != a_q[WIDTH-1]))
                                       : add_s[WIDTH];
                    end
                    OP_SUB: begin
                        res_d = sub_s[WIDTH-1:0];
                        c_d   = sub_s[WIDTH];
                        ovf_d = mode_q ? ((a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                          (sub_s[WIDTH-1] != a_q[WIDTH-1]))
                                       : sub_s[WIDTH];
                    end
                    OP_SHL: begin
                        res_d = {a_q[WIDTH-2:0], 1'b0};
                        c_d   = a_q[WIDTH-1];
                        ovf_d = mode_q && (a_q[WIDTH-1] ^ a_q[WIDTH-2]);
                    end
                    OP_SHR: begin
                        res_d = {mode_q & a_q[WIDTH-1], a_q[WIDTH-1:1]};
                        c_d   = a_q[0];
                    end
                    default: begin
                        res_d = '0;
                        ovf_d = 1'b1;
                    end
                endcase
                zero_d  = (res_d == '0);
                state_d = S_DONE;
            end

            S_PREP: begin
                hi_d    = '0;
                cnt_d   = CW'(WIDTH - 1);
                m_d     = (op_q == OP_MUL) ? mag_a : mag_b;
                lo_d    = (op_q == OP_MUL) ? mag_b : mag_a;
                state_d = S_ITER;
            end

            S_ITER: begin
                if (op_q == OP_MUL) begin
                    hi_d = mul_s[WIDTH:1];
                    lo_d = {mul_s[0], lo_q[WIDTH-1:1]};
                end else begin
                    hi_d = div_ge ? div_trial : div_rs[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], div_ge};
                end
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_FIX: begin
                c_d = 1'b0;
                if (op_q == OP_MUL) begin
                    res_d    = prod_s[WIDTH-1:0];
                    res_hi_d = prod_s[2*WIDTH-1:WIDTH];
                    ovf_d    = mode_q ? (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}})
                                      : (prod_s[2*WIDTH-1:WIDTH] != '0);
                end else if (b_q == '0) begin
                    res_d    = ALL_ONES;
                    res_hi_d = a_q;
                    ovf_d    = 1'b1;
                end else if (mode_q && a_q == MOST_NEG && b_q == ALL_ONES) begin
                    res_d    = a_q;
                    res_hi_d = '0;
                    ovf_d    = 1'b1;
                end else begin
                    res_d    = quo_s;
                    res_hi_d = rem_s;
                    ovf_d    = 1'b0;
                end
                zero_d  = (res_d == '0);
                state_d = S_DONE;
            end

            S_DONE: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign bus.req_ready     = (state_q == S_IDLE);
    assign bus.rsp_valid     = (state_q == S_DONE);
    assign bus.rsp_result    = res_q;
    assign bus.rsp_result_hi = res_hi_q;
    assign bus.rsp_c_out     = c_q;
    assign bus.rsp_overflow  = ovf_q;
    assign bus.rsp_zero      = zero_q;

endmodule
